// File: rtl/seg_pkg.sv
// Shared constants, glyph table entries and scan state type for the
// seven-segment scan controller.
package seg_pkg;

  localparam int NDIG = 8;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [7:0] AN_OFF    = 8'hFF;

  // Active-low {g,f,e,d,c,b,a} glyphs for hex digits 0..F
  localparam logic [6:0] GLYPH_0 = 7'h40;
  localparam logic [6:0] GLYPH_1 = 7'h79;
  localparam logic [6:0] GLYPH_2 = 7'h24;
  localparam logic [6:0] GLYPH_3 = 7'h30;
  localparam logic [6:0] GLYPH_4 = 7'h19;
  localparam logic [6:0] GLYPH_5 = 7'h12;
  localparam logic [6:0] GLYPH_6 = 7'h02;
  localparam logic [6:0] GLYPH_7 = 7'h78;
  localparam logic [6:0] GLYPH_8 = 7'h00;
  localparam logic [6:0] GLYPH_9 = 7'h10;
  localparam logic [6:0] GLYPH_A = 7'h08;
  localparam logic [6:0] GLYPH_B = 7'h03;
  localparam logic [6:0] GLYPH_C = 7'h46;
  localparam logic [6:0] GLYPH_D = 7'h21;
  localparam logic [6:0] GLYPH_E = 7'h06;
  localparam logic [6:0] GLYPH_F = 7'h0E;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_e;

endpackage

// File: rtl/hex7seg.sv
// Combinational hex nibble to active-low seven-segment glyph decoder.
module hex7seg
  import seg_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (nib_i)
      4'h0: seg_o = GLYPH_0;
      4'h1: seg_o = GLYPH_1;
      4'h2: seg_o = GLYPH_2;
      4'h3: seg_o = GLYPH_3;
      4'h4: seg_o = GLYPH_4;
      4'h5: seg_o = GLYPH_5;
      4'h6: seg_o = GLYPH_6;
      4'h7: seg_o = GLYPH_7;
      4'h8: seg_o = GLYPH_8;
      4'h9: seg_o = GLYPH_9;
      4'hA: seg_o = GLYPH_A;
      4'hB: seg_o = GLYPH_B;
      4'hC: seg_o = GLYPH_C;
      4'hD: seg_o = GLYPH_D;
      4'hE: seg_o = GLYPH_E;
      4'hF: seg_o = GLYPH_F;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// 8-digit multiplexed seven-segment scan controller with per-slot blanking
// and frame-boundary double-buffered display value (load/ack handshake).
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int TICK_DIV  = 50000,
  parameter int BLANK_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_in,
  input  logic [7:0]  dp_in,
  input  logic [7:0]  en_in,
  input  logic        load,
  output logic        load_ack,
  output logic        frame_start,
  output logic [2:0]  sel,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int             CW        = $clog2(TICK_DIV);
  localparam logic [CW-1:0]  CNT_MAX   = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0]  BLANK_LIM = CW'(BLANK_CYC);
  localparam logic [2:0]     SEL_LAST  = 3'(NDIG - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    sel_q, sel_d;
  scan_state_e   state_q, state_d;
  logic [31:0]   data_q, data_d;
  logic [7:0]    dpm_q, dpm_d;
  logic [7:0]    en_q, en_d;
  logic [7:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          ack_q, ack_d;
  logic          fs_q, fs_d;

  logic          wrap, boundary, capture;
  logic [3:0]    nib;
  logic [6:0]    glyph;

  // State register: everything, including the pin drivers, resets dark.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      sel_q   <= '0;
      state_q <= ST_BLANK;
      data_q  <= '0;
      dpm_q   <= '0;
      en_q    <= '0;
      an_q    <= AN_OFF;
      seg_q   <= SEG_BLANK;
      dp_q    <= 1'b1;
      ack_q   <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      state_q <= state_d;
      data_q  <= data_d;
      dpm_q   <= dpm_d;
      en_q    <= en_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      ack_q   <= ack_d;
      fs_q    <= fs_d;
    end
  end

  // Next-state: slot counter, digit index, slot phase and shadow capture.
  always_comb begin
    wrap     = (cnt_q == CNT_MAX);
    boundary = wrap && (sel_q == SEL_LAST);
    capture  = boundary && load;
    cnt_d    = wrap ? '0 : cnt_q + CW'(1);
    sel_d    = wrap ? sel_q + 3'd1 : sel_q;
    state_d  = (cnt_d < BLANK_LIM) ? ST_BLANK : ST_DRIVE;
    data_d   = capture ? data_in : data_q;
    dpm_d    = capture ? dp_in   : dpm_q;
    en_d     = capture ? en_in   : en_q;
    ack_d    = capture;
    fs_d     = boundary;
  end

  // Decode from next-state values so the pins line up with cnt/sel.
  assign nib = data_d[{sel_d, 2'b00} +: 4];

  hex7seg u_dec (
    .nib_i (nib),
    .seg_o (glyph)
  );

  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    if (state_d == ST_DRIVE && en_d[sel_d]) begin
      an_d  = ~(8'h01 << sel_d);
      seg_d = glyph;
      dp_d  = ~dpm_d[sel_d];
    end
  end

  assign load_ack    = ack_q;
  assign frame_start = fs_q;
  assign sel         = sel_q;
  assign an          = an_q;
  assign seg         = seg_q;
  assign dp          = dp_q;

endmodule
